// File: rtl/pad_cfg_loader_pkg.sv
// Shared definitions for the serial pad-configuration loader: frame opcodes,
// FSM states, pad config field positions and the post-reset pad word.
package pad_cfg_loader_pkg;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_WRITE  = 2'b01,
    OP_READ   = 2'b10,
    OP_COMMIT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE,
    ST_WAIT
  } state_e;

  localparam int FRAME_LEN = 16;
  localparam int CFG_W     = 7;

  // Bit positions inside the 7-bit per-pad word {dm2,dm1,dm0,ib,vtrip,slow,ieb}
  localparam int FLD_DM2     = 6;
  localparam int FLD_DM1     = 5;
  localparam int FLD_DM0     = 4;
  localparam int FLD_IB_MODE = 3;
  localparam int FLD_VTRIP   = 2;
  localparam int FLD_SLOW    = 1;
  localparam int FLD_IEB     = 0;

  typedef logic [CFG_W-1:0] pad_cfg_t;

  // Input-only drive mode (dm = 3'b001), all other selects cleared
  localparam pad_cfg_t PAD_CFG_DEFAULT = 7'b001_0000;

  function automatic logic [FRAME_LEN-1:0] read_resp(input logic [5:0] idx, input pad_cfg_t word);
    return {OP_READ, idx, 1'b0, word};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

endpackage

// File: rtl/pad_cfg_loader_if.sv
// Serial configuration port: chip select, clock and data towards the loader,
// readback data and its pad output-enable back to the host.
interface pad_cfg_loader_if;
  logic scs_n;
  logic sclk;
  logic sdi;
  logic sdo;
  logic sdo_oeb;

  modport master (output scs_n, output sclk, output sdi, input sdo, input sdo_oeb);
  modport slave  (input scs_n, input sclk, input sdi, output sdo, output sdo_oeb);
endinterface

// File: rtl/pad_cfg_sync.sv
// Multi-stage synchroniser for asynchronous inputs; each bit resets to its
// own idle level so a reset never fabricates an edge on the synced copy.
module pad_cfg_sync #(
  parameter int               STAGES  = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [STAGES];

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_reg[i] <= RST_VAL;
      end
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/pad_cfg_loader.sv
// Serial pad-configuration loader: 16-bit frames update a shadow bank, COMMIT
// publishes it to the pad outputs, READ returns a shadow word on the next frame.
module pad_cfg_loader
  import pad_cfg_loader_pkg::*;
#(
  parameter int NPADS       = 44,  // matches `OPENFRAME_IO_PADS
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             resetb,
  pad_cfg_loader_if.slave  spi,
  output logic [NPADS-1:0] gpio_dm2,
  output logic [NPADS-1:0] gpio_dm1,
  output logic [NPADS-1:0] gpio_dm0,
  output logic [NPADS-1:0] gpio_ib_mode_sel,
  output logic [NPADS-1:0] gpio_vtrip_sel,
  output logic [NPADS-1:0] gpio_slow_sel,
  output logic [NPADS-1:0] gpio_ieb,
  output logic             cfg_valid,
  output logic             commit_pulse,
  output logic [7:0]       err_cnt
);

  localparam int PW = $clog2(SYNC_STAGES + 1);
  localparam int BW = $clog2(FRAME_LEN);

  logic scs_n_s;
  logic sclk_s;
  logic sdi_s;

  pad_cfg_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b1)) u_sync_scs_n (
    .clk(clk), .resetb(resetb), .d(spi.scs_n), .q(scs_n_s)
  );
  pad_cfg_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .resetb(resetb), .d(spi.sclk), .q(sclk_s)
  );
  pad_cfg_sync #(.STAGES(SYNC_STAGES), .WIDTH(1), .RST_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .resetb(resetb), .d(spi.sdi), .q(sdi_s)
  );

  state_e                 state_reg;
  logic [BW-1:0]          bit_cnt_reg;
  logic [FRAME_LEN-1:0]   frame_reg;
  logic [FRAME_LEN-1:0]   resp_reg;
  logic [FRAME_LEN-1:0]   tx_shift_reg;
  logic                   scs_n_d_reg;
  logic                   sclk_d_reg;
  logic [PW-1:0]          prime_cnt_reg;
  logic                   sdo_reg;
  logic                   sdo_oeb_reg;
  logic                   commit_pulse_reg;
  logic                   cfg_valid_reg;
  logic [7:0]             err_cnt_reg;
  logic                   wr_en_reg;
  logic [5:0]             wr_idx_reg;
  pad_cfg_t               wr_data_reg;

  pad_cfg_t shadow_reg [NPADS];
  pad_cfg_t active_reg [NPADS];

  logic     primed;
  logic     scs_fall;
  logic     scs_rise;
  logic     sclk_rise;
  logic     sclk_fall;
  op_e      frame_op;
  logic [5:0] frame_idx;
  pad_cfg_t frame_data;
  logic     idx_ok;
  logic     commit_now;
  pad_cfg_t rd_word;

  // The synced chip select shows its reset level for SYNC_STAGES cycles after
  // reset; edges are only trusted once real pin samples have reached the end.
  assign primed    = (prime_cnt_reg == PW'(SYNC_STAGES));
  assign scs_fall  = ~scs_n_s & scs_n_d_reg;
  assign scs_rise  = scs_n_s & ~scs_n_d_reg;
  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign sclk_fall = ~sclk_s & sclk_d_reg;

  assign frame_op   = op_e'(frame_reg[15:14]);
  assign frame_idx  = frame_reg[13:8];
  assign frame_data = frame_reg[CFG_W-1:0];
  assign idx_ok     = (int'(frame_idx) < NPADS);
  assign commit_now = (state_reg == ST_DONE) && (frame_op == OP_COMMIT);

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NPADS; i++) begin
      if (int'(frame_idx) == i) begin
        rd_word = shadow_reg[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_reg        <= ST_IDLE;
      bit_cnt_reg      <= '0;
      frame_reg        <= '0;
      resp_reg         <= '0;
      tx_shift_reg     <= '0;
      scs_n_d_reg      <= 1'b0;
      sclk_d_reg       <= 1'b0;
      prime_cnt_reg    <= '0;
      sdo_reg          <= 1'b0;
      sdo_oeb_reg      <= 1'b1;
      commit_pulse_reg <= 1'b0;
      cfg_valid_reg    <= 1'b0;
      err_cnt_reg      <= '0;
      wr_en_reg        <= 1'b0;
      wr_idx_reg       <= '0;
      wr_data_reg      <= PAD_CFG_DEFAULT;
    end else begin
      if (!primed) begin
        prime_cnt_reg <= prime_cnt_reg + PW'(1);
      end
      scs_n_d_reg      <= primed ? scs_n_s : 1'b0;
      sclk_d_reg       <= sclk_s;
      sdo_oeb_reg      <= scs_n_s;
      commit_pulse_reg <= 1'b0;
      wr_en_reg        <= 1'b0;

      // Readback: snapshot the pending response at frame start, then present
      // one bit per sclk falling edge so the host samples on the rising edge.
      if (scs_fall) begin
        tx_shift_reg <= resp_reg;
      end else if (!scs_n_s && sclk_fall) begin
        sdo_reg      <= tx_shift_reg[FRAME_LEN-1];
        tx_shift_reg <= {tx_shift_reg[FRAME_LEN-2:0], 1'b0};
      end

      case (state_reg)
        ST_IDLE: begin
          if (scs_fall) begin
            state_reg   <= ST_SHIFT;
            bit_cnt_reg <= '0;
          end
        end
        ST_SHIFT: begin
          if (scs_rise) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= '0;
            err_cnt_reg <= sat_inc8(err_cnt_reg);
          end else if (sclk_rise) begin
            frame_reg <= {frame_reg[FRAME_LEN-2:0], sdi_s};
            if (bit_cnt_reg == BW'(FRAME_LEN - 1)) begin
              state_reg   <= ST_DONE;
              bit_cnt_reg <= '0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BW'(1);
            end
          end
        end
        ST_DONE: begin
          state_reg <= scs_rise ? ST_IDLE : ST_WAIT;
          resp_reg  <= '0;
          case (frame_op)
            OP_WRITE: begin
              if (idx_ok) begin
                wr_en_reg   <= 1'b1;
                wr_idx_reg  <= frame_idx;
                wr_data_reg <= frame_data;
              end else begin
                err_cnt_reg <= sat_inc8(err_cnt_reg);
              end
            end
            OP_READ: begin
              if (idx_ok) begin
                resp_reg <= read_resp(frame_idx, rd_word);
              end else begin
                err_cnt_reg <= sat_inc8(err_cnt_reg);
              end
            end
            OP_COMMIT: begin
              commit_pulse_reg <= 1'b1;
              cfg_valid_reg    <= 1'b1;
            end
            default: ;
          endcase
        end
        ST_WAIT: begin
          if (scs_rise) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < NPADS; i++) begin
        shadow_reg[i] <= PAD_CFG_DEFAULT;
        active_reg[i] <= PAD_CFG_DEFAULT;
      end
    end else begin
      for (int i = 0; i < NPADS; i++) begin
        if (wr_en_reg && int'(wr_idx_reg) == i) begin
          shadow_reg[i] <= wr_data_reg;
        end
        if (commit_now) begin
          active_reg[i] <= shadow_reg[i];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NPADS; gi++) begin : g_pad
    pad_cfg_t word;
    assign word                 = cfg_valid_reg ? active_reg[gi] : PAD_CFG_DEFAULT;
    assign gpio_dm2[gi]         = word[FLD_DM2];
    assign gpio_dm1[gi]         = word[FLD_DM1];
    assign gpio_dm0[gi]         = word[FLD_DM0];
    assign gpio_ib_mode_sel[gi] = word[FLD_IB_MODE];
    assign gpio_vtrip_sel[gi]   = word[FLD_VTRIP];
    assign gpio_slow_sel[gi]    = word[FLD_SLOW];
    assign gpio_ieb[gi]         = word[FLD_IEB];
  end

  assign spi.sdo      = sdo_reg;
  assign spi.sdo_oeb  = sdo_oeb_reg;
  assign cfg_valid    = cfg_valid_reg;
  assign commit_pulse = commit_pulse_reg;
  assign err_cnt      = err_cnt_reg;

endmodule

// File: tb/tb_pad_cfg_loader.sv
// Randomised scoreboard bench for pad_cfg_loader: a frame-level model predicts
// sdo readback words, commit snapshots, error counts and pad outputs.
module tb_pad_cfg_loader;

  localparam int NP = 44;
  localparam int P  = 5;
  localparam int PW = 7 * NP;
  localparam logic [1:0] OPN = 2'd0, OPW = 2'd1, OPR = 2'd2, OPC = 2'd3;
  localparam logic [6:0] DEF = 7'b001_0000;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  pad_cfg_loader_if bus ();

  logic [NP-1:0] dm2, dm1, dm0, ibm, vtr, slw, ieb;
  logic          cfg_valid, commit_pulse;
  logic [7:0]    err_cnt;

  pad_cfg_loader #(.NPADS(NP), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetb(resetb), .spi(bus),
    .gpio_dm2(dm2), .gpio_dm1(dm1), .gpio_dm0(dm0),
    .gpio_ib_mode_sel(ibm), .gpio_vtrip_sel(vtr), .gpio_slow_sel(slw), .gpio_ieb(ieb),
    .cfg_valid(cfg_valid), .commit_pulse(commit_pulse), .err_cnt(err_cnt)
  );

  int n_pass = 0;
  int n_checks = 0;

  logic [6:0]  m_shadow [NP];
  logic [6:0]  m_active [NP];
  bit          m_valid;
  int          m_err;
  logic [15:0] m_resp;

  logic [15:0]   sdo_q [$];
  logic [PW-1:0] commit_q [$];

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [PW-1:0] model_pads();
    logic [NP-1:0] v [7];
    for (int f = 0; f < 7; f++) v[f] = '0;
    for (int i = 0; i < NP; i++) begin
      logic [6:0] w;
      w = m_valid ? m_active[i] : DEF;
      for (int f = 0; f < 7; f++) v[f][i] = w[f];
    end
    return {v[6], v[5], v[4], v[3], v[2], v[1], v[0]};
  endfunction

  function automatic logic [PW-1:0] dut_pads();
    return {dm2, dm1, dm0, ibm, vtr, slw, ieb};
  endfunction

  function automatic int sat(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_shadow[i] = DEF;
      m_active[i] = DEF;
    end
    m_valid = 0;
    m_err   = 0;
    m_resp  = '0;
  endtask

  task automatic drive(input logic [15:0] w, input int nbits, input bit raise);
    @(negedge clk) bus.scs_n = 1'b0;
    repeat (P) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      bus.sdi = w[15-k];
      repeat (P) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (P) @(negedge clk);
      bus.sclk = 1'b0;
    end
    repeat (P) @(negedge clk);
    if (raise) begin
      bus.scs_n = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic do_frame(input logic [1:0] op, input logic [5:0] idx, input logic [6:0] data, input int nbits);
    logic [15:0] nr;
    nr = '0;
    if (nbits < 16) begin
      m_err = sat(m_err);
    end else begin
      sdo_q.push_back(m_resp);
      case (op)
        OPW: if (idx < NP) m_shadow[idx] = data; else m_err = sat(m_err);
        OPR: if (idx < NP) nr = {2'b10, idx, 1'b0, m_shadow[idx]}; else m_err = sat(m_err);
        OPC: begin
          for (int i = 0; i < NP; i++) m_active[i] = m_shadow[i];
          m_valid = 1;
          commit_q.push_back(model_pads());
        end
        default: ;
      endcase
      m_resp = nr;
    end
    drive({op, idx, 1'b0, data}, nbits, 1'b1);
    $display("frame op=%0d idx=%0d data=%02h bits=%0d err_cnt=%0d", op, idx, data, nbits, err_cnt);
    check("err_cnt", err_cnt, m_err);
    check("pads", dut_pads(), model_pads());
    check("cfg_valid", cfg_valid, m_valid);
    check("sdo_oeb_idle", bus.sdo_oeb, 1'b1);
  endtask

  // sdo monitor: collect one bit per host sclk fall, compare full frames
  initial begin
    forever begin
      logic [15:0] word;
      int nb;
      @(negedge bus.scs_n);
      nb = 0;
      word = '0;
      while (bus.scs_n == 1'b0) begin
        @(negedge bus.sclk or posedge bus.scs_n);
        if (bus.scs_n == 1'b0) begin
          repeat (4) @(posedge clk);
          #1;
          word = {word[14:0], bus.sdo};
          nb++;
          check("sdo_oeb_active", bus.sdo_oeb, 1'b0);
        end
      end
      if (nb == 16) begin
        if (sdo_q.size() == 0) check("sdo_expect_avail", sdo_q.size(), 1);
        else check("sdo_frame", word, sdo_q.pop_front());
      end
    end
  end

  // commit monitor: pads must match the model snapshot while the pulse is high
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (commit_pulse) begin
        if (commit_q.size() == 0) begin
          check("commit_spurious", commit_pulse, 1'b0);
        end else begin
          check("commit_pads", dut_pads(), commit_q.pop_front());
          check("commit_cfg_valid", cfg_valid, 1'b1);
          @(posedge clk);
          #1;
          check("commit_pulse_width", commit_pulse, 1'b0);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.scs_n = 1'b1;
    bus.sclk  = 1'b0;
    bus.sdi   = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    resetb = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_err_cnt", err_cnt, 0);
    check("reset_cfg_valid", cfg_valid, 1'b0);
    check("reset_commit_pulse", commit_pulse, 1'b0);
    check("reset_sdo", bus.sdo, 1'b0);
    check("reset_sdo_oeb", bus.sdo_oeb, 1'b1);
    check("reset_pads", dut_pads(), model_pads());

    // pad 5 becomes dm=011, everything else stays input-only
    do_frame(OPW, 6'd5, 7'b0110000, 16);
    do_frame(OPC, 6'd0, 7'd0, 16);
    check("pad5_dm", {dm2[5], dm1[5], dm0[5]}, 3'b011);
    check("pad4_dm", {dm2[4], dm1[4], dm0[4]}, 3'b001);

    // write / read / nop: readback word appears on the NOP frame
    do_frame(OPW, 6'd3, 7'h55, 16);
    do_frame(OPR, 6'd3, 7'd0, 16);
    do_frame(OPN, 6'd0, 7'd0, 16);

    // out-of-range pad index
    do_frame(OPW, 6'd44, 7'h7F, 16);
    do_frame(OPR, 6'd44, 7'd0, 16);
    do_frame(OPN, 6'd0, 7'd0, 16);

    // short frame is dropped, next frames behave normally
    do_frame(OPW, 6'd7, 7'h01, 9);
    do_frame(OPW, 6'd7, 7'h2A, 16);
    do_frame(OPW, 6'd7, 7'h13, 16);
    do_frame(OPC, 6'd0, 7'd0, 16);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      logic [5:0] idx;
      int nb;
      op  = 2'($urandom_range(0, 3));
      idx = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(44, 63)) :
            ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 9)) : 6'($urandom_range(0, 43));
      nb  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : 16;
      do_frame(op, idx, 7'($urandom), nb);
    end
    do_frame(OPR, 6'd43, 7'd0, 16);
    do_frame(OPN, 6'd0, 7'd0, 16);

    // reset in the middle of a COMMIT frame
    do_frame(OPW, 6'd10, 7'h7F, 16);
    do_frame(OPC, 6'd0, 7'd0, 16);
    do_frame(OPW, 6'd11, 7'h22, 16);
    drive(16'hC000, 8, 1'b0);
    @(negedge clk) resetb = 1'b0;
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    repeat (4) @(negedge clk);
    bus.scs_n = 1'b1;
    repeat (8) @(negedge clk);
    model_reset();
    $display("reset mid-commit frame: cfg_valid=%0d err_cnt=%0d", cfg_valid, err_cnt);
    check("midreset_pads", dut_pads(), model_pads());
    check("midreset_cfg_valid", cfg_valid, 1'b0);
    check("midreset_err_cnt", err_cnt, 0);
    check("midreset_sdo_oeb", bus.sdo_oeb, 1'b1);
    do_frame(OPC, 6'd0, 7'd0, 16);

    // error counter saturation
    for (int n = 0; n < 300; n++) begin
      do_frame(OPW, 6'd1, 7'h00, 1);
    end
    check("err_cnt_saturated", err_cnt, 8'd255);

    repeat (20) @(negedge clk);
    check("sdo_q_drained", sdo_q.size(), 0);
    check("commit_q_drained", commit_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pad_cfg_loader.md
PAD_CFG_LOADER -- requirements
Module: pad_cfg_loader

Interface
REQ-001 Parameter NPADS, default 44: number of pads served; equals `OPENFRAME_IO_PADS.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth on serial inputs.
REQ-003 One clock; reset is asynchronous and active-low; ports are named clk and resetb.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 resetb  in  1  asynchronous active-low reset.
REQ-006 scs_n, sclk, sdi  in  1 each  serial config port (from gpio_in), asynchronous to clk.
REQ-007 sdo  out  1  serial readback data.
REQ-008 sdo_oeb  out  1  output-enable, active-low, for the sdo pad.
REQ-009 gpio_dm2, gpio_dm1, gpio_dm0  out  NPADS each  pad drive-mode bits.
REQ-010 gpio_ib_mode_sel, gpio_vtrip_sel, gpio_slow_sel, gpio_ieb  out  NPADS each  pad config bits.
REQ-011 cfg_valid  out  1  high once the first COMMIT has been applied.
REQ-012 commit_pulse  out  1  one-cycle strobe on each COMMIT.
REQ-013 err_cnt  out  8  saturating count of rejected frames.

Function
REQ-014 scs_n, sclk and sdi each pass through SYNC_STAGES flops; all logic uses synchronised copies only.
REQ-015 A bit is sampled on each synchronised sclk rising edge while scs_n is low, MSB first.
REQ-016 A frame is exactly 16 bits: [15:14] op, [13:8] pad index, [7] reserved, [6:0] data = {dm2,dm1,dm0,ib_mode_sel,vtrip_sel,slow_sel,ieb}.
REQ-017 Ops: 00 NOP, 01 WRITE, 10 READ, 11 COMMIT.
REQ-018 FSM states: IDLE (scs_n high), SHIFT (counting bits 0..15), DONE (one cycle, executes op), WAIT (bits beyond 16 are ignored until scs_n rises).
REQ-019 Transitions: IDLE->SHIFT on scs_n fall; SHIFT->DONE after the 16th sample; DONE->WAIT; any state->IDLE on scs_n rise.
REQ-020 scs_n rising in SHIFT with fewer than 16 bits discards the frame: no state change, err_cnt increments.
REQ-021 WRITE updates shadow[index] one clk after DONE; active outputs are unchanged.
REQ-022 COMMIT copies all NPADS shadow words to active in the DONE cycle; outputs change on the next edge; commit_pulse is high for that cycle; cfg_valid sets and stays set until reset.
REQ-023 READ loads the response register with {2'b10, index, 1'b0, shadow[index]} at DONE; that register is shifted out on sdo during the next frame, MSB first.
REQ-024 sdo updates on each synchronised sclk falling edge while scs_n is low; sdo_oeb is low only while scs_n is low, and high otherwise.
REQ-025 An index >= NPADS on WRITE or READ is rejected: no shadow change, the READ response is all zeros, and err_cnt increments.
REQ-026 err_cnt saturates at 255.
REQ-027 A frame that neither READs nor errs loads a response of all zeros.
REQ-028 A second WRITE to the same index before COMMIT overwrites the first; the last write wins.
REQ-029 While cfg_valid is low, all pad outputs drive reset defaults regardless of shadow contents.

Reset
REQ-030 resetb low forces state IDLE, bit counter 0, sdo 0, sdo_oeb 1, commit_pulse 0, cfg_valid 0, and err_cnt 0.
REQ-031 Reset forces every shadow and active word to dm=3'b001 (input-only) and ib_mode_sel=vtrip_sel=slow_sel=ieb=0.
REQ-032 Reset clears all synchroniser flops to their idle levels: scs_n=1, sclk=0, sdi=0.
REQ-033 Reset asserted mid-frame aborts the frame without incrementing err_cnt.

Structure
REQ-034 The shared package holds the op encodings, the 7-bit pad config field positions, the frame length 16, and the reset default word.
REQ-035 One sub-module, pad_cfg_sync, implements the SYNC_STAGES synchroniser with a per-bit reset value; it is instantiated three times.
REQ-036 The shadow and active banks are flop arrays; no memory macro is used.

Verification
REQ-037 WRITE idx 5, data 7'b0110000, then COMMIT -> after commit gpio_dm*[5] = 3'b011; all other pads remain 3'b001; commit_pulse high for 1 clk; cfg_valid = 1.
REQ-038 WRITE idx 3, data 7'h55, then READ idx 3, then NOP -> sdo during the NOP frame = 16'h8355; active outputs are unchanged.
REQ-039 WRITE idx 44 (NPADS=44) -> err_cnt = 1 and no shadow change; a READ of idx 44 returns 16'h0000.
REQ-040 Raise scs_n after 9 bits -> frame discarded, err_cnt +1, FSM returns to IDLE; the next full frame executes normally.
REQ-041 Drive 300 aborted frames -> err_cnt holds at 255.
REQ-042 Assert resetb mid-COMMIT frame after prior writes -> all outputs return to defaults, cfg_valid = 0, and the subsequent COMMIT applies the reset defaults.
